// File: rtl/dom_sbox_pkg.sv
// dom_sbox_pkg: share width, Z pair-to-offset mapping, GF(2^2) squaring.
// No ports; imported by the inverter tail, its interface and sub-module.
package dom_sbox_pkg;

  localparam int SHARE_W = 2;

  function automatic int n_pairs(input int shares);
    return shares * (shares - 1) / 2;
  endfunction

  // row-major index of pair (i,j) with i<j
  function automatic int pair_idx(
    input int shares,
    input int i,
    input int j
  );
    return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // (i,j) and (j,i) map to the same Z slice
  function automatic int z_off(
    input int shares,
    input int i,
    input int j
  );
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return pair_idx(shares, lo, hi) * SHARE_W;
  endfunction

  // normal-basis square is a bit swap
  function automatic logic [SHARE_W-1:0] gf4_sq(
    input logic [SHARE_W-1:0] x
  );
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/dom_shared_inv_gf4_tail_if.sv
// Bundle for the masked GF(2^4) inverter tail: valid, A halves, delta, Z in;
// shared Qhi/Qlo and valid out. master = driver side, slave = the tail.
interface dom_shared_inv_gf4_tail_if #(
  parameter int SHARES = 2
);
  import dom_sbox_pkg::*;

  localparam int W  = SHARE_W * SHARES;
  localparam int ZW = 2 * SHARE_W * n_pairs(SHARES);

  logic          ValidxSI;
  logic [W-1:0]  AhixDI;
  logic [W-1:0]  AloxDI;
  logic [W-1:0]  DeltaxDI;
  logic [ZW-1:0] ZxDI;
  logic [W-1:0]  QhixDO;
  logic [W-1:0]  QloxDO;
  logic          ValidxSO;

  modport master (
    output ValidxSI, AhixDI, AloxDI, DeltaxDI, ZxDI,
    input  QhixDO, QloxDO, ValidxSO
  );

  modport slave (
    input  ValidxSI, AhixDI, AloxDI, DeltaxDI, ZxDI,
    output QhixDO, QloxDO, ValidxSO
  );

endinterface

// File: rtl/dom_indep_mul_gf2.sv
// dom_indep_mul_gf2: DOM-indep GF(2^2) multiplier, registered inner/cross terms.
// Ports: ClkxCI, RstxBI, shared XxDI/YxDI, fresh ZxDI, shared product QxDO.
module dom_indep_mul_gf2
  import dom_sbox_pkg::*;
#(
  parameter int SHARES    = 2,
  parameter int PIPELINED = 1
) (
  input  logic                                ClkxCI,
  input  logic                                RstxBI,
  input  logic [SHARE_W*SHARES-1:0]           XxDI,
  input  logic [SHARE_W*SHARES-1:0]           YxDI,
  input  logic [SHARE_W*n_pairs(SHARES)-1:0]  ZxDI,
  output logic [SHARE_W*SHARES-1:0]           QxDO
);

  logic [SHARES-1:0][SHARE_W-1:0] x_s;
  logic [SHARES-1:0][SHARE_W-1:0] y_s;
  logic [SHARES-1:0][SHARE_W-1:0] q_s;
  logic [SHARE_W-1:0] prod [SHARES][SHARES];
  logic [SHARES-1:0][SHARES-1:0][SHARE_W-1:0] term_d;
  logic [SHARES-1:0][SHARES-1:0][SHARE_W-1:0] term_q;

  assign x_s = XxDI;
  assign y_s = YxDI;

  for (genvar i = 0; i < SHARES; i++) begin : g_i
    for (genvar j = 0; j < SHARES; j++) begin : g_j
      gf2_mul #(.N(SHARE_W)) u_mul (
        .AxDI (x_s[i]),
        .BxDI (y_s[j]),
        .QxDO (prod[i][j])
      );
    end
  end

  // cross terms are remasked before they reach a register
  always_comb begin
    term_d = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        term_d[i][j] = prod[i][j];
        if (i != j) begin
          term_d[i][j] = prod[i][j]
                       ^ ZxDI[z_off(SHARES, i, j) +: SHARE_W];
        end
      end
    end
  end

  if (PIPELINED != 0) begin : g_reg
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        term_q <= '0;
      end else begin
        term_q <= term_d;
      end
    end
  end else begin : g_comb
    assign term_q = term_d;
  end

  always_comb begin
    q_s = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        q_s[i] = q_s[i] ^ term_q[i][j];
      end
    end
  end

  assign QxDO = q_s;

endmodule

// File: rtl/gf2_mul.sv
// gf2_mul: GF(2^2) multiply in normal basis {W^2, W}.
// Ports: AxDI, BxDI operands; QxDO product. Purely combinational.
module gf2_mul #(
  parameter int N = 2
) (
  input  logic [N-1:0] AxDI,
  input  logic [N-1:0] BxDI,
  output logic [N-1:0] QxDO
);

  logic e;

  always_comb begin
    e = (AxDI[1] ^ AxDI[0]) & (BxDI[1] ^ BxDI[0]);
    QxDO = '0;
    QxDO[1] = (AxDI[1] & BxDI[1]) ^ e;
    QxDO[0] = (AxDI[0] & BxDI[0]) ^ e;
  end

endmodule

// File: rtl/dom_shared_inv_gf4_tail.sv
// dom_shared_inv_gf4_tail: masked GF(2^4) inverse tail (delta^-1 times A halves).
// Ports: ClkxCI, RstxBI (async, low) and bus (slave): valid/A/delta/Z in, Q out.
module dom_shared_inv_gf4_tail
  import dom_sbox_pkg::*;
#(
  parameter int SHARES        = 2,
  parameter int DELTA_LATENCY = 1
) (
  input logic                      ClkxCI,
  input logic                      RstxBI,
  dom_shared_inv_gf4_tail_if.slave bus
);

  localparam int W  = SHARE_W * SHARES;
  localparam int ZH = SHARE_W * n_pairs(SHARES);
  localparam int DW = 2 * W + 1;

  logic [DW-1:0] a_in;
  logic [DW-1:0] a_dly;
  logic          valid_dly;
  logic [W-1:0]  ahi_dly;
  logic [W-1:0]  alo_dly;
  logic [SHARES-1:0][SHARE_W-1:0] delta_s;
  logic [SHARES-1:0][SHARE_W-1:0] dinv_s;
  logic valid_d;
  logic valid_q;

  assign a_in = {bus.ValidxSI, bus.AhixDI, bus.AloxDI};

  if (DELTA_LATENCY > 0) begin : g_dly
    logic [DELTA_LATENCY-1:0][DW-1:0] dly_d;
    logic [DELTA_LATENCY-1:0][DW-1:0] dly_q;

    always_comb begin
      dly_d = '0;
      dly_d[0] = a_in;
      for (int s = 1; s < DELTA_LATENCY; s++) begin
        dly_d[s] = dly_q[s-1];
      end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        dly_q <= '0;
      end else begin
        dly_q <= dly_d;
      end
    end

    assign a_dly = dly_q[DELTA_LATENCY-1];
  end else begin : g_thru
    assign a_dly = a_in;
  end

  assign {valid_dly, ahi_dly, alo_dly} = a_dly;
  assign delta_s = bus.DeltaxDI;

  // GF(2^2) inverse is the square, applied share-wise
  always_comb begin
    dinv_s = '0;
    for (int i = 0; i < SHARES; i++) begin
      dinv_s[i] = gf4_sq(delta_s[i]);
    end
  end

  assign valid_d = valid_dly;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  dom_indep_mul_gf2 #(
    .SHARES    (SHARES),
    .PIPELINED (1)
  ) u_mul_hi (
    .ClkxCI (ClkxCI),
    .RstxBI (RstxBI),
    .XxDI   (dinv_s),
    .YxDI   (alo_dly),
    .ZxDI   (bus.ZxDI[ZH-1:0]),
    .QxDO   (bus.QhixDO)
  );

  dom_indep_mul_gf2 #(
    .SHARES    (SHARES),
    .PIPELINED (1)
  ) u_mul_lo (
    .ClkxCI (ClkxCI),
    .RstxBI (RstxBI),
    .XxDI   (dinv_s),
    .YxDI   (ahi_dly),
    .ZxDI   (bus.ZxDI[2*ZH-1:ZH]),
    .QxDO   (bus.QloxDO)
  );

  assign bus.ValidxSO = valid_q;

endmodule

// File: tb/tb_dom_shared_inv_gf4_tail.sv
// Bench for dom_shared_inv_gf4_tail: SHARES=2/LAT=1 and SHARES=3/LAT=0.
// Driver pushes expected inverse and due cycle; monitors pop on ValidxSO.
module tb_dom_shared_inv_gf4_tail;

  typedef struct {
    logic [3:0] val;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit         pend = 1'b0;
  logic [1:0] pend_d = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dom_shared_inv_gf4_tail_if #(.SHARES(2)) if0 ();
  dom_shared_inv_gf4_tail_if #(.SHARES(3)) if1 ();

  dom_shared_inv_gf4_tail #(
    .SHARES        (2),
    .DELTA_LATENCY (1)
  ) dut0 (
    .ClkxCI (clk),
    .RstxBI (rst_n),
    .bus    (if0)
  );

  dom_shared_inv_gf4_tail #(
    .SHARES        (3),
    .DELTA_LATENCY (0)
  ) dut1 (
    .ClkxCI (clk),
    .RstxBI (rst_n),
    .bus    (if1)
  );

  function automatic logic [1:0] g4_mul(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] g4_sq(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  function automatic logic [1:0] g4_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [3:0] g16_mul(
    input logic [3:0] x,
    input logic [3:0] y
  );
    logic [1:0] e;
    e = g4_scl_n(g4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {g4_mul(x[3:2], y[3:2]) ^ e, g4_mul(x[1:0], y[1:0]) ^ e};
  endfunction

  // unity in this normal basis is 4'b1111; inv(0) stays 0
  function automatic logic [3:0] g16_inv(input logic [3:0] x);
    logic [3:0] r;
    r = 4'h0;
    for (int y = 0; y < 16; y++) begin
      if (g16_mul(x, 4'(y)) == 4'hF) r = 4'(y);
    end
    return r;
  endfunction

  // upstream square-scale-multiply stage
  function automatic logic [1:0] delta_of(input logic [3:0] x);
    return g4_scl_n(g4_sq(x[3:2] ^ x[1:0])) ^ g4_mul(x[3:2], x[1:0]);
  endfunction

  function automatic logic [5:0] split(
    input logic [1:0] x,
    input int         s
  );
    logic [5:0] r;
    logic [1:0] acc;
    r = '0;
    acc = x;
    for (int i = 1; i < s; i++) begin
      r[2*i +: 2] = 2'($urandom);
      acc = acc ^ r[2*i +: 2];
    end
    r[1:0] = acc;
    return r;
  endfunction

  function automatic logic [1:0] unmask(
    input logic [5:0] v,
    input int         s
  );
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < s; i++) r = r ^ v[2*i +: 2];
    return r;
  endfunction

  task automatic step(
    input bit         v,
    input logic [3:0] x,
    input logic [3:0] e,
    input bit         zz,
    input bit         junk
  );
    logic [5:0] t;
    @(negedge clk);
    if0.ValidxSI = v;
    if1.ValidxSI = v;
    if (v) begin
      t = split(x[3:2], 2);
      if0.AhixDI = t[3:0];
      t = split(x[1:0], 2);
      if0.AloxDI = t[3:0];
      if1.AhixDI = split(x[3:2], 3);
      if1.AloxDI = split(x[1:0], 3);
      if1.DeltaxDI = split(delta_of(x), 3);
      if1.ZxDI = zz ? 12'h0 : 12'($urandom);
      q0.push_back('{e, cyc + 2});
      q1.push_back('{e, cyc + 1});
    end else if (junk) begin
      if0.AhixDI = 4'($urandom);
      if0.AloxDI = 4'($urandom);
      if1.AhixDI = 6'($urandom);
      if1.AloxDI = 6'($urandom);
      if1.DeltaxDI = 6'($urandom);
      if1.ZxDI = 12'($urandom);
    end else begin
      if0.AhixDI = '0;
      if0.AloxDI = '0;
      if1.AhixDI = '0;
      if1.AloxDI = '0;
      if1.DeltaxDI = '0;
      if1.ZxDI = '0;
    end
    if (pend) begin
      t = split(pend_d, 2);
      if0.DeltaxDI = t[3:0];
      if0.ZxDI = zz ? 4'h0 : 4'($urandom);
    end else if (junk) begin
      if0.DeltaxDI = 4'($urandom);
      if0.ZxDI = 4'($urandom);
    end else begin
      if0.DeltaxDI = '0;
      if0.ZxDI = '0;
    end
    pend = v;
    pend_d = delta_of(x);
  endtask

  task automatic chk_zero(input string nm);
    n_cmp++;
    if ({if0.ValidxSO, if0.QhixDO, if0.QloxDO} !== 9'h0) begin
      n_bad++;
      $display("FAIL %s_d0 got v=%b hi=%h lo=%h want all 0",
               nm, if0.ValidxSO, if0.QhixDO, if0.QloxDO);
    end
    n_cmp++;
    if ({if1.ValidxSO, if1.QhixDO, if1.QloxDO} !== 13'h0) begin
      n_bad++;
      $display("FAIL %s_d1 got v=%b hi=%h lo=%h want all 0",
               nm, if1.ValidxSO, if1.QhixDO, if1.QloxDO);
    end
  endtask

  task automatic chk_valid(input string nm, input logic want);
    n_cmp++;
    if (if0.ValidxSO !== want) begin
      n_bad++;
      $display("FAIL %s_d0 got=%b want=%b", nm, if0.ValidxSO, want);
    end
    n_cmp++;
    if (if1.ValidxSO !== want) begin
      n_bad++;
      $display("FAIL %s_d1 got=%b want=%b", nm, if1.ValidxSO, want);
    end
  endtask

  initial begin
    exp_t e;
    logic [3:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (if0.ValidxSO === 1'b1) begin
        n_cmp++;
        got = {unmask(6'(if0.QhixDO), 2), unmask(6'(if0.QloxDO), 2)};
        if (q0.size() == 0) begin
          n_bad++;
          $display("FAIL d0_stale got=%h cyc=%0d want none", got, cyc);
        end else begin
          e = q0.pop_front();
          if (got !== e.val || cyc != e.due) begin
            n_bad++;
            $display("FAIL d0_out got=%h@%0d want=%h@%0d",
                     got, cyc, e.val, e.due);
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    logic [3:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (if1.ValidxSO === 1'b1) begin
        n_cmp++;
        got = {unmask(6'(if1.QhixDO), 3), unmask(6'(if1.QloxDO), 3)};
        if (q1.size() == 0) begin
          n_bad++;
          $display("FAIL d1_stale got=%h cyc=%0d want none", got, cyc);
        end else begin
          e = q1.pop_front();
          if (got !== e.val || cyc != e.due) begin
            n_bad++;
            $display("FAIL d1_out got=%h@%0d want=%h@%0d",
                     got, cyc, e.val, e.due);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    #1;
    chk_zero("reset");
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) begin
      step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      chk_zero("release");
    end

    step(1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    for (int x = 0; x < 16; x++) begin
      step(1'b1, 4'(x), g16_inv(4'(x)), 1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    step(1'b1, 4'h3, g16_inv(4'h3), 1'b0, 1'b0);
    step(1'b1, 4'h8, g16_inv(4'h8), 1'b0, 1'b0);
    step(1'b1, 4'hC, g16_inv(4'hC), 1'b0, 1'b0);
    #1;
    chk_valid("pre_rst_valid", 1'b1);
    rst_n = 1'b0;
    #1;
    chk_valid("rst_valid_drop", 1'b0);
    q0.delete();
    q1.delete();
    pend = 1'b0;
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 4'h5, g16_inv(4'h5), 1'b0, 1'b0);
    repeat (3) step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    for (int x = 0; x < 16; x++) begin
      step(1'b1, 4'(x), g16_inv(4'(x)), 1'b1, 1'b0);
    end

    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 20) begin
      step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      guard++;
    end
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL d0_drain got=%0d pending want=0", q0.size());
    end
    n_cmp++;
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL d1_drain got=%0d pending want=0", q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
